button_debounce_array: RTL and testbench

BUTTON_DEBOUNCE_ARRAY -- requirements
Module: button_debounce_array

---
 rtl/button_debounce_array_if.sv | 41 ++++
 rtl/button_debounce_array.sv | 189 ++++++++++++++++++
 tb/tb_button_debounce_array.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_debounce_array_if.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce_array_if
// Description : Bundles the raw button inputs and the per-channel debounce
//               event outputs of button_debounce_array.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_debounce_array_if #(
    parameter int N_CH = 5
);
    logic [N_CH-1:0] i_button;
    logic [N_CH-1:0] o_level;
    logic [N_CH-1:0] o_press;
    logic [N_CH-1:0] o_release;
    logic [N_CH-1:0] o_hold;
    logic [N_CH-1:0] o_repeat;
    logic            o_any_press;

    // Environment side: drives raw buttons, observes events
    modport master (
        output i_button,
        input  o_level,
        input  o_press,
        input  o_release,
        input  o_hold,
        input  o_repeat,
        input  o_any_press
    );

    // Debouncer side: samples raw buttons, produces events
    modport slave (
        input  i_button,
        output o_level,
        output o_press,
        output o_release,
        output o_hold,
        output o_repeat,
        output o_any_press
    );
endinterface
`default_nettype wire

// File: rtl/button_debounce_array.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce_array
// Description : N_CH independent button debouncers. Each channel synchronises
//               its raw input, debounces press/release with a 4-state FSM and
//               generates press, release, long-press and auto-repeat pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce_array #(
    parameter int N_CH         = 5,
    parameter int DEB_COUNT    = 1000000,
    parameter int HOLD_COUNT   = 50000000,
    parameter int REPEAT_COUNT = 10000000,
    parameter int REPEAT_EN    = 1
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst,
    button_debounce_array_if.slave bus
);

    localparam int c_DEB_W  = $clog2(DEB_COUNT) + 1;
    localparam int c_HOLD_W = $clog2(HOLD_COUNT) + 1;
    localparam int c_REP_W  = $clog2(REPEAT_COUNT) + 1;

    localparam logic [c_DEB_W-1:0]  c_DEB_ONE  = c_DEB_W'(1);
    localparam logic [c_DEB_W-1:0]  c_DEB_LAST = c_DEB_W'(DEB_COUNT - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_COUNT - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(HOLD_COUNT);
    localparam logic [c_REP_W-1:0]  c_REP_ONE  = c_REP_W'(1);
    localparam logic [c_REP_W-1:0]  c_REP_LAST = c_REP_W'(REPEAT_COUNT - 1);
    localparam logic                c_REP_ON   = (REPEAT_EN != 0);

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] S_PRESSED      = 2'd2;
    localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

    logic [N_CH-1:0] w_press_evt;
    logic [N_CH-1:0] w_level;
    logic [N_CH-1:0] w_press;
    logic [N_CH-1:0] w_release;
    logic [N_CH-1:0] w_hold;
    logic [N_CH-1:0] w_repeat;
    logic            r_any_press;

    generate
        for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
            logic [1:0]          r_sync;
            logic [1:0]          r_state;
            logic [c_DEB_W-1:0]  r_deb;
            logic [c_HOLD_W-1:0] r_hold_cnt;
            logic [c_REP_W-1:0]  r_rep_cnt;
            logic                r_press;
            logic                r_release;
            logic                r_hold;
            logic                r_repeat;

            logic w_sync;
            logic w_in_level;
            logic w_release_evt;
            logic w_hold_done;
            logic w_hold_evt;
            logic w_repeat_evt;

            assign w_sync     = r_sync[1];
            assign w_in_level = (r_state == S_PRESSED) || (r_state == S_RELEASE_WAIT);

            // Debounce completions: the counter already holds DEB_COUNT-1
            // consecutive samples, so this sample is the DEB_COUNT-th.
            assign w_press_evt[ch] = (r_state == S_PRESS_WAIT) && w_sync &&
                                     (r_deb == c_DEB_LAST);
            assign w_release_evt   = (r_state == S_RELEASE_WAIT) && !w_sync &&
                                     (r_deb == c_DEB_LAST);

            // A release completing in the same cycle wins over hold/repeat
            assign w_hold_done  = (r_hold_cnt == c_HOLD_MAX);
            assign w_hold_evt   = w_in_level && (r_hold_cnt == c_HOLD_LAST) &&
                                  !w_release_evt;
            assign w_repeat_evt = c_REP_ON && w_in_level && w_hold_done &&
                                  (r_rep_cnt == c_REP_LAST) && !w_release_evt;

            // Synchroniser, debounce FSM, hold/repeat counters and pulse registers
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_sync     <= 2'b00;
                    r_state    <= S_IDLE;
                    r_deb      <= '0;
                    r_hold_cnt <= '0;
                    r_rep_cnt  <= '0;
                    r_press    <= 1'b0;
                    r_release  <= 1'b0;
                    r_hold     <= 1'b0;
                    r_repeat   <= 1'b0;
                end else begin
                    r_sync    <= {r_sync[0], bus.i_button[ch]};
                    r_press   <= w_press_evt[ch];
                    r_release <= w_release_evt;
                    r_hold    <= w_hold_evt;
                    r_repeat  <= w_repeat_evt;

                    case (r_state)
                        S_IDLE: begin
                            if (w_sync) begin
                                r_state <= S_PRESS_WAIT;
                                r_deb   <= c_DEB_ONE;
                            end else begin
                                r_deb   <= '0;
                            end
                        end
                        S_PRESS_WAIT: begin
                            if (!w_sync) begin
                                r_state <= S_IDLE;
                                r_deb   <= '0;
                            end else if (r_deb == c_DEB_LAST) begin
                                r_state <= S_PRESSED;
                                r_deb   <= '0;
                            end else begin
                                r_deb   <= r_deb + c_DEB_ONE;
                            end
                        end
                        S_PRESSED: begin
                            if (!w_sync) begin
                                r_state <= S_RELEASE_WAIT;
                                r_deb   <= c_DEB_ONE;
                            end
                        end
                        S_RELEASE_WAIT: begin
                            if (w_sync) begin
                                // Short low glitch: back to pressed silently
                                r_state <= S_PRESSED;
                                r_deb   <= '0;
                            end else if (r_deb == c_DEB_LAST) begin
                                r_state <= S_IDLE;
                                r_deb   <= '0;
                            end else begin
                                r_deb   <= r_deb + c_DEB_ONE;
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_deb   <= '0;
                        end
                    endcase

                    // Hold counter saturates at HOLD_COUNT; repeat counter only
                    // runs once the hold point has been reached.
                    if (!w_in_level || w_release_evt) begin
                        r_hold_cnt <= '0;
                        r_rep_cnt  <= '0;
                    end else begin
                        if (!w_hold_done) begin
                            r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
                        end
                        if (w_hold_evt) begin
                            r_rep_cnt <= '0;
                        end else if (w_hold_done) begin
                            r_rep_cnt <= (r_rep_cnt == c_REP_LAST) ? '0 : r_rep_cnt + c_REP_ONE;
                        end
                    end
                end
            end

            assign w_level[ch]   = w_in_level;
            assign w_press[ch]   = r_press;
            assign w_release[ch] = r_release;
            assign w_hold[ch]    = r_hold;
            assign w_repeat[ch]  = r_repeat;
        end
    endgenerate

    // Any-press flag registered from the same events as the per-channel press bits
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_any_press <= 1'b0;
        end else begin
            r_any_press <= |w_press_evt;
        end
    end

    assign bus.o_level     = w_level;
    assign bus.o_press     = w_press;
    assign bus.o_release   = w_release;
    assign bus.o_hold      = w_hold;
    assign bus.o_repeat    = w_repeat;
    assign bus.o_any_press = r_any_press;

endmodule
`default_nettype wire

// File: tb/tb_button_debounce_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debounce_array
// Description : Self-checking bench for button_debounce_array. Two instances
//               (auto-repeat on / off) share stimulus and are compared against
//               a run-length / press-age reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debounce_array;

    localparam int N    = 4;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn = '0;

    int checks = 0;
    int errors = 0;

    button_debounce_array_if #(.N_CH(N)) bus_a ();
    button_debounce_array_if #(.N_CH(N)) bus_b ();

    assign bus_a.i_button = btn;
    assign bus_b.i_button = btn;

    button_debounce_array #(
        .N_CH(N), .DEB_COUNT(DEB), .HOLD_COUNT(HOLD), .REPEAT_COUNT(REP), .REPEAT_EN(1)
    ) u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a)
    );

    button_debounce_array #(
        .N_CH(N), .DEB_COUNT(DEB), .HOLD_COUNT(HOLD), .REPEAT_COUNT(REP), .REPEAT_EN(0)
    ) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    wire logic [5*N:0] act_a = {bus_a.o_level, bus_a.o_press, bus_a.o_release,
                                bus_a.o_hold, bus_a.o_repeat, bus_a.o_any_press};
    wire logic [5*N:0] act_b = {bus_b.o_level, bus_b.o_press, bus_b.o_release,
                                bus_b.o_hold, bus_b.o_repeat, bus_b.o_any_press};

    // Reference model: sync delay line, run of samples disagreeing with the
    // accepted level, and age of the current press in cycles.
    bit m_s1 [N];
    bit m_s2 [N];
    bit m_lvl[N];
    int m_run[N];
    int m_age[N];
    logic [5*N:0] exp_a;
    logic [5*N:0] exp_b;

    task automatic step();
        logic [N-1:0] e_level, e_press, e_release, e_hold, e_repeat;
        bit s;
        @(posedge clk);
        e_level = '0; e_press = '0; e_release = '0; e_hold = '0; e_repeat = '0;
        for (int c = 0; c < N; c++) begin
            if (rst) begin
                m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_run[c] = 0; m_age[c] = 0;
            end else begin
                s = m_s2[c];
                m_run[c] = (s != m_lvl[c]) ? m_run[c] + 1 : 0;
                if (m_run[c] == DEB) begin
                    if (m_lvl[c]) e_release[c] = 1'b1;
                    else          e_press[c]   = 1'b1;
                    m_lvl[c] = !m_lvl[c];
                    m_run[c] = 0;
                    m_age[c] = 0;
                end else if (m_lvl[c]) begin
                    m_age[c]++;
                    if (m_age[c] == HOLD) e_hold[c] = 1'b1;
                    if (m_age[c] > HOLD && ((m_age[c] - HOLD) % REP) == 0) e_repeat[c] = 1'b1;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = btn[c];
            end
            e_level[c] = m_lvl[c];
        end
        exp_a = {e_level, e_press, e_release, e_hold, e_repeat, |e_press};
        exp_b = {e_level, e_press, e_release, e_hold, {N{1'b0}}, |e_press};
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn = N'($urandom);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (act_a !== '0) begin
                errors++;
                $display("FAIL reset_a cycle %0d got %h want 0", k, act_a);
            end
            checks++;
            if (act_b !== '0) begin
                errors++;
                $display("FAIL reset_b cycle %0d got %h want 0", k, act_b);
            end
        end
        btn = '0;
        rst = 1'b0;
    endtask

    task automatic test_press_latency();
        int first = -1;
        int npress = 0;
        int nany = 0;
        btn = '0;
        repeat (12) step();
        btn[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (act_a !== exp_a) begin
                errors++;
                $display("FAIL latency_model t=%0t got %h want %h", $time, act_a, exp_a);
            end
            if (bus_a.o_press[0]) begin
                npress++;
                if (first < 0) first = k;
            end
            if (bus_a.o_any_press) nany++;
        end
        checks++;
        if (first !== 6) begin
            errors++;
            $display("FAIL press_latency got %0d want 6", first);
        end
        checks++;
        if (npress !== 1 || nany !== 1) begin
            errors++;
            $display("FAIL press_single got press=%0d any=%0d want 1/1", npress, nany);
        end
        checks++;
        if (bus_a.o_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL level0 got %b want 1", bus_a.o_level[0]);
        end
    endtask

    task automatic test_bounce();
        int npress = 0;
        int nrel = 0;
        btn = '0;
        repeat (12) step();
        for (int k = 0; k < 12; k++) begin
            btn[1] = (k < 3);
            step();
            checks++;
            if (act_a !== exp_a) begin
                errors++;
                $display("FAIL bounce_model t=%0t got %h want %h", $time, act_a, exp_a);
            end
            if (bus_a.o_press[1] || bus_a.o_level[1]) npress++;
        end
        checks++;
        if (npress !== 0) begin
            errors++;
            $display("FAIL short_press got %0d level/press cycles want 0", npress);
        end
        for (int k = 0; k < 25; k++) begin
            btn[1] = (k != 12);
            step();
            checks++;
            if (act_b !== exp_b) begin
                errors++;
                $display("FAIL glitch_model t=%0t got %h want %h", $time, act_b, exp_b);
            end
            if (bus_a.o_release[1]) nrel++;
        end
        checks++;
        if (nrel !== 0 || bus_a.o_level[1] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_release got rel=%0d level=%b want 0/1", nrel, bus_a.o_level[1]);
        end
    endtask

    task automatic test_hold_repeat();
        int p = -1, h = -1, r1 = -1, rl = -1, rel = -1;
        int nhold = 0, nrep_a = 0, nrep_b = 0, nhold_b = 0, nrel = 0;
        btn = '0;
        repeat (12) step();
        btn[2] = 1'b1;
        for (int k = 1; k <= 75; k++) begin
            if (k == 46) btn[2] = 1'b0;
            step();
            checks++;
            if (act_a !== exp_a) begin
                errors++;
                $display("FAIL hold_model_a t=%0t got %h want %h", $time, act_a, exp_a);
            end
            checks++;
            if (act_b !== exp_b) begin
                errors++;
                $display("FAIL hold_model_b t=%0t got %h want %h", $time, act_b, exp_b);
            end
            if (bus_a.o_press[2]) p = k;
            if (bus_a.o_hold[2]) begin nhold++; h = k; end
            if (bus_b.o_hold[2]) nhold_b++;
            if (bus_a.o_repeat[2]) begin nrep_a++; rl = k; if (r1 < 0) r1 = k; end
            if (bus_b.o_repeat[2]) nrep_b++;
            if (bus_a.o_release[2]) begin nrel++; rel = k; end
        end
        checks++;
        if (nhold !== 1 || (h - p) !== HOLD) begin
            errors++;
            $display("FAIL hold_offset got n=%0d off=%0d want 1/%0d", nhold, h - p, HOLD);
        end
        checks++;
        if ((r1 - h) !== REP || nrep_a !== 4) begin
            errors++;
            $display("FAIL repeat_a got first=%0d n=%0d want %0d/4", r1 - h, nrep_a, REP);
        end
        checks++;
        if (nrel !== 1 || rl >= rel) begin
            errors++;
            $display("FAIL release_stop got rel=%0d last_rep=%0d rel_at=%0d", nrel, rl, rel);
        end
        checks++;
        if (nrep_b !== 0 || nhold_b !== 1) begin
            errors++;
            $display("FAIL repeat_disabled got rep=%0d hold=%0d want 0/1", nrep_b, nhold_b);
        end
    endtask

    task automatic test_simultaneous();
        int nany = 0;
        int nfull = 0;
        int npart = 0;
        btn = '0;
        repeat (40) step();
        btn = '1;
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if (act_a !== exp_a) begin
                errors++;
                $display("FAIL simul_model t=%0t got %h want %h", $time, act_a, exp_a);
            end
            if (bus_a.o_any_press) nany++;
            if (bus_a.o_press == 4'b1111) nfull++;
            else if (bus_a.o_press != 4'b0000) npart++;
        end
        checks++;
        if (nany !== 1 || nfull !== 1 || npart !== 0) begin
            errors++;
            $display("FAIL simul_press got any=%0d full=%0d partial=%0d want 1/1/0", nany, nfull, npart);
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        btn = '0;
        repeat (40) step();
        btn[3] = 1'b1;
        repeat (5) step();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (act_a !== '0) begin
                errors++;
                $display("FAIL reset_mid cycle %0d got %h want 0", k, act_a);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (act_a !== exp_a) begin
                errors++;
                $display("FAIL rearm_model t=%0t got %h want %h", $time, act_a, exp_a);
            end
            if (bus_a.o_press[3] && first < 0) first = k;
        end
        checks++;
        if (first !== 6) begin
            errors++;
            $display("FAIL rearm_latency got %0d want 6", first);
        end
    endtask

    task automatic test_random();
        int cnt[N];
        for (int c = 0; c < N; c++) cnt[c] = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N; c++) begin
                if (cnt[c] == 0) begin
                    btn[c] = ~btn[c];
                    cnt[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(25, 60))
                                                         : int'($urandom_range(1, 6));
                end else begin
                    cnt[c]--;
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
            checks++;
            if (act_a !== exp_a) begin
                errors++;
                $display("FAIL random_a t=%0t got %h want %h", $time, act_a, exp_a);
            end
            checks++;
            if (act_b !== exp_b) begin
                errors++;
                $display("FAIL random_b t=%0t got %h want %h", $time, act_b, exp_b);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_bounce();
        test_hold_repeat();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
